// File: rtl/keypad_scan_sequencer_pkg.sv
// keypad_scan_sequencer_pkg
// Shared definitions for the 3x3 keypad scanner: FSM state encoding,
// key/column widths, the idle column drive value and the row decoder.
package keypad_scan_sequencer_pkg;

  localparam int KEY_W    = 4;
  localparam int NUM_COLS = 3;
  localparam logic [NUM_COLS-1:0] COL_IDLE = 3'b111;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    HELD,
    RELEASE
  } scan_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } row_hit_t;

  // A sample is a hit only when exactly one row line is pulled low; no low
  // line or several low lines (ghosting / multi-press) both read as no key.
  function automatic row_hit_t decode_row(input logic [2:0] row_sync);
    row_hit_t r;
    r.hit = 1'b1;
    r.idx = 2'd0;
    case (row_sync)
      3'b110:  r.idx = 2'd0;
      3'b101:  r.idx = 2'd1;
      3'b011:  r.idx = 2'd2;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_sequencer_if.sv
// keypad_scan_sequencer_if
// Key event handshake between the scanner (master) and its consumer (slave).
//   key       scanner -> consumer  key code {col_idx, row_idx}
//   key_valid scanner -> consumer  event pending, held until accepted
//   key_ack   consumer -> scanner  accept the pending event
//   key_down  scanner -> consumer  a confirmed key is currently held
//   overrun   scanner -> consumer  sticky, a confirmed press was dropped
interface keypad_scan_sequencer_if;
  import keypad_scan_sequencer_pkg::*;

  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             key_ack;
  logic             key_down;
  logic             overrun;

  modport master (
    output key,
    output key_valid,
    output key_down,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key,
    input  key_valid,
    input  key_down,
    input  overrun,
    output key_ack
  );

endinterface

// File: rtl/keypad_scan_sequencer_scan_tick.sv
// scan_tick
// Column dwell timer. Counts 0..DIV-1 and pulses tick for the one cycle the
// count sits at DIV-1. Held at 0 while disabled or cleared.
//   clk     system clock
//   clear   synchronous active-high reset
//   enable  count enable
//   tick    one-cycle pulse at the end of each dwell
module scan_tick #(
  parameter int DIV = 5000
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (clear || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/keypad_scan_sequencer.sv
// keypad_scan_sequencer
// Scans a 3x3 active-low keypad one column at a time, debounces presses and
// releases, and hands confirmed presses to a consumer over a valid/ack
// handshake with overrun reporting.
//   clk     system clock
//   clear   synchronous active-high reset
//   enable  scan enable, low = idle (columns released, FSM parked)
//   row     keypad row sense, active-low, asynchronous
//   column  column drive, active-low, one-hot-low while scanning
//   ev      key event handshake (master side)
module keypad_scan_sequencer
  import keypad_scan_sequencer_pkg::*;
#(
  parameter int SCAN_DIV     = 5000,
  parameter int DEBOUNCE_CNT = 6
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [2:0]           row,
  output logic [NUM_COLS-1:0]  column,
  keypad_scan_sequencer_if.master ev
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 2);
  // Press is confirmed on the sample that takes the count to DEBOUNCE_CNT+1;
  // release completes on the sample that takes it to DEBOUNCE_CNT.
  localparam logic [CW-1:0] PRESS_LAST   = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(DEBOUNCE_CNT - 1);

  logic [2:0]       row_meta;
  logic [2:0]       row_sync;
  logic             tick;
  scan_state_t      state;
  logic [1:0]       col_idx;
  logic [1:0]       col_next;
  logic [CW-1:0]    match_cnt;
  logic [KEY_W-1:0] cand;
  logic [KEY_W-1:0] sample_key;
  row_hit_t         sample;
  logic             match;
  logic             post;

  scan_tick #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk    (clk),
    .clear  (clear),
    .enable (enable),
    .tick   (tick)
  );

  // Two-flop synchronizer; idles at all-released so reset never looks like a key.
  always_ff @(posedge clk) begin
    if (clear) begin
      row_meta <= 3'b111;
      row_sync <= 3'b111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign sample     = decode_row(row_sync);
  assign sample_key = {col_idx, sample.idx};
  assign match      = sample.hit && (sample_key == cand);
  assign col_next   = (col_idx == 2'(NUM_COLS - 1)) ? 2'd0 : col_idx + 2'd1;
  assign post       = tick && (state == CONFIRM) && match && (match_cnt == PRESS_LAST);
  assign column     = enable ? ~(3'b001 << col_idx) : COL_IDLE;

  // Scan/debounce FSM. col_idx stays frozen outside SCAN so the same column
  // remains driven while a candidate key is being confirmed or held.
  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      match_cnt   <= '0;
      cand        <= '0;
      ev.key_down <= 1'b0;
    end else if (!enable) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      match_cnt   <= '0;
      ev.key_down <= 1'b0;
    end else if (tick) begin
      case (state)
        SCAN: begin
          if (sample.hit) begin
            cand      <= sample_key;
            match_cnt <= CW'(1);
            state     <= CONFIRM;
          end else begin
            col_idx <= col_next;
          end
        end
        CONFIRM: begin
          if (post) begin
            state       <= HELD;
            match_cnt   <= '0;
            ev.key_down <= 1'b1;
          end else if (match) begin
            match_cnt <= match_cnt + CW'(1);
          end else begin
            state     <= SCAN;
            match_cnt <= '0;
            col_idx   <= col_next;
          end
        end
        HELD: begin
          ev.key_down <= 1'b1;
          if (!sample.hit) begin
            state     <= RELEASE;
            match_cnt <= CW'(1);
          end
        end
        RELEASE: begin
          if (sample.hit) begin
            state     <= HELD;
            match_cnt <= '0;
          end else if (match_cnt >= RELEASE_LAST) begin
            state       <= SCAN;
            match_cnt   <= '0;
            col_idx     <= col_next;
            ev.key_down <= 1'b0;
          end else begin
            match_cnt <= match_cnt + CW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  // Event handshake. A post while an unaccepted event is pending is dropped
  // and flagged; an ack in the same cycle frees the slot so the post lands.
  always_ff @(posedge clk) begin
    if (clear) begin
      ev.key       <= '0;
      ev.key_valid <= 1'b0;
      ev.overrun   <= 1'b0;
    end else if (post) begin
      if (!ev.key_valid || ev.key_ack) begin
        ev.key       <= cand;
        ev.key_valid <= 1'b1;
      end else begin
        ev.overrun <= 1'b1;
      end
    end else if (ev.key_ack && ev.key_valid) begin
      ev.key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// tb_keypad_scan_sequencer
// Directed bench for keypad_scan_sequencer with SCAN_DIV=4, DEBOUNCE_CNT=3.
// A small keypad model drives row from the DUT column drive for one pressed
// key, with an override for multi-key patterns. Cycle numbers below count
// clock cycles since the last clear edge (cycle 0 follows that edge).
module tb_keypad_scan_sequencer;
  import keypad_scan_sequencer_pkg::*;

  logic       clk;
  logic       clear;
  logic       enable;
  logic [2:0] row;
  logic [2:0] column;

  keypad_scan_sequencer_if ev_if ();

  keypad_scan_sequencer #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk    (clk),
    .clear  (clear),
    .enable (enable),
    .row    (row),
    .column (column),
    .ev     (ev_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic       key_pressed;
  logic [1:0] press_col;
  logic [1:0] press_row;
  logic       force_en;
  logic [2:0] force_row;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter restarted by every clear edge.
  always @(posedge clk) begin
    if (clear) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Keypad model: the pressed key pulls its row low only while its column is driven.
  always_comb begin
    if (force_en)
      row = force_row;
    else if (key_pressed && (column[press_col] == 1'b0))
      row = ~(3'b001 << press_row);
    else
      row = 3'b111;
  end

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic press(input logic [1:0] c, input logic [1:0] r);
    press_col   = c;
    press_row   = r;
    key_pressed = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    do_reset();
    checks++; if (column !== 3'b110) begin errors++; $display("[TB] FAIL reset_column: got %b expected %b", column, 3'b110); end
    checks++; if (ev_if.key !== 4'b0000) begin errors++; $display("[TB] FAIL reset_key: got %b expected %b", ev_if.key, 4'b0000); end
    checks++; if (ev_if.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_valid: got %b expected 0", ev_if.key_valid); end
    checks++; if (ev_if.key_down !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_down: got %b expected 0", ev_if.key_down); end
    checks++; if (ev_if.overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", ev_if.overrun); end
  endtask

  task automatic test_scan_sequence();
    logic [2:0] exp_col;
    logic       saw_valid;
    key_pressed = 1'b0;
    do_reset();
    saw_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      wait_cycle(c);
      // An ack with nothing pending must be ignored.
      ev_if.key_ack = (c == 1);
      exp_col = ~(3'b001 << ((c / 4) % 3));
      checks++; if (column !== exp_col) begin errors++; $display("[TB] FAIL scan_column c%0d: got %b expected %b", c, column, exp_col); end
      if (ev_if.key_valid !== 1'b0) saw_valid = 1'b1;
    end
    ev_if.key_ack = 1'b0;
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("[TB] FAIL scan_no_event: got %b expected 0", saw_valid); end
  endtask

  task automatic test_press_ack_release();
    press(2'd2, 2'd1);
    do_reset();
    // First hit tick is cycle 11; key_valid must appear 13 cycles later.
    wait_cycle(23);
    checks++; if (ev_if.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL press_early_valid: got %b expected 0", ev_if.key_valid); end
    checks++; if (ev_if.key_down !== 1'b0) begin errors++; $display("[TB] FAIL press_early_down: got %b expected 0", ev_if.key_down); end
    wait_cycle(24);
    checks++; if (ev_if.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL press_valid: got %b expected 1", ev_if.key_valid); end
    checks++; if (ev_if.key !== 4'b1001) begin errors++; $display("[TB] FAIL press_key: got %b expected %b", ev_if.key, 4'b1001); end
    checks++; if (ev_if.key_down !== 1'b1) begin errors++; $display("[TB] FAIL press_down: got %b expected 1", ev_if.key_down); end
    checks++; if (column !== 3'b011) begin errors++; $display("[TB] FAIL press_column_frozen: got %b expected %b", column, 3'b011); end
    wait_cycle(26);
    ev_if.key_ack = 1'b1;
    wait_cycle(27);
    ev_if.key_ack = 1'b0;
    checks++; if (ev_if.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL ack_clears_valid: got %b expected 0", ev_if.key_valid); end
    checks++; if (ev_if.key_down !== 1'b1) begin errors++; $display("[TB] FAIL ack_keeps_down: got %b expected 1", ev_if.key_down); end
    wait_cycle(28);
    key_pressed = 1'b0;
    // No-key samples at ticks 31, 35, 39 complete the release.
    wait_cycle(39);
    checks++; if (ev_if.key_down !== 1'b1) begin errors++; $display("[TB] FAIL release_early: got %b expected 1", ev_if.key_down); end
    wait_cycle(40);
    checks++; if (ev_if.key_down !== 1'b0) begin errors++; $display("[TB] FAIL release_down: got %b expected 0", ev_if.key_down); end
    checks++; if (column !== 3'b110) begin errors++; $display("[TB] FAIL release_column: got %b expected %b", column, 3'b110); end
  endtask

  task automatic test_bounce();
    logic saw_event;
    press(2'd2, 2'd0);
    do_reset();
    wait_cycle(12);
    key_pressed = 1'b0;
    wait_cycle(15);
    checks++; if (column !== 3'b011) begin errors++; $display("[TB] FAIL bounce_frozen: got %b expected %b", column, 3'b011); end
    saw_event = 1'b0;
    for (int c = 16; c <= 48; c++) begin
      wait_cycle(c);
      if (c == 16) begin
        checks++; if (column !== 3'b110) begin errors++; $display("[TB] FAIL bounce_resume_col0: got %b expected %b", column, 3'b110); end
      end
      if (c == 20) begin
        checks++; if (column !== 3'b101) begin errors++; $display("[TB] FAIL bounce_col1: got %b expected %b", column, 3'b101); end
      end
      if (ev_if.key_valid !== 1'b0 || ev_if.key_down !== 1'b0) saw_event = 1'b1;
    end
    checks++; if (saw_event !== 1'b0) begin errors++; $display("[TB] FAIL bounce_no_event: got %b expected 0", saw_event); end
  endtask

  task automatic test_multi_low();
    logic saw_event;
    logic col_bad;
    logic [2:0] exp_col;
    key_pressed = 1'b0;
    force_en    = 1'b1;
    force_row   = 3'b100;
    do_reset();
    saw_event = 1'b0;
    col_bad   = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      wait_cycle(c);
      exp_col = ~(3'b001 << ((c / 4) % 3));
      if (column !== exp_col) col_bad = 1'b1;
      if (ev_if.key_valid !== 1'b0 || ev_if.key_down !== 1'b0) saw_event = 1'b1;
    end
    force_en = 1'b0;
    checks++; if (col_bad !== 1'b0) begin errors++; $display("[TB] FAIL multi_low_scanning: got %b expected 0", col_bad); end
    checks++; if (saw_event !== 1'b0) begin errors++; $display("[TB] FAIL multi_low_no_event: got %b expected 0", saw_event); end
  endtask

  // Key A (col1,row2) posts at cycle 19; key B (col2,row0) posts at cycle 47.
  task automatic run_two_presses();
    press(2'd1, 2'd2);
    do_reset();
    wait_cycle(20);
    checks++; if (ev_if.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %b expected 1", ev_if.key_valid); end
    checks++; if (ev_if.key !== 4'b0110) begin errors++; $display("[TB] FAIL first_key: got %b expected %b", ev_if.key, 4'b0110); end
    wait_cycle(21);
    press(2'd2, 2'd0);
  endtask

  task automatic test_overrun();
    run_two_presses();
    wait_cycle(47);
    checks++; if (ev_if.overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_early: got %b expected 0", ev_if.overrun); end
    wait_cycle(48);
    checks++; if (ev_if.overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %b expected 1", ev_if.overrun); end
    checks++; if (ev_if.key !== 4'b0110) begin errors++; $display("[TB] FAIL overrun_key_kept: got %b expected %b", ev_if.key, 4'b0110); end
    checks++; if (ev_if.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL overrun_valid: got %b expected 1", ev_if.key_valid); end
    checks++; if (ev_if.key_down !== 1'b1) begin errors++; $display("[TB] FAIL overrun_down: got %b expected 1", ev_if.key_down); end
  endtask

  task automatic test_back_to_back();
    run_two_presses();
    wait_cycle(47);
    ev_if.key_ack = 1'b1;
    wait_cycle(48);
    ev_if.key_ack = 1'b0;
    checks++; if (ev_if.key !== 4'b1000) begin errors++; $display("[TB] FAIL b2b_key: got %b expected %b", ev_if.key, 4'b1000); end
    checks++; if (ev_if.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid: got %b expected 1", ev_if.key_valid); end
    checks++; if (ev_if.overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun: got %b expected 0", ev_if.overrun); end
    wait_cycle(49);
    ev_if.key_ack = 1'b1;
    wait_cycle(50);
    ev_if.key_ack = 1'b0;
    checks++; if (ev_if.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ack: got %b expected 0", ev_if.key_valid); end
  endtask

  task automatic test_clear_and_enable();
    press(2'd0, 2'd1);
    do_reset();
    // Hit at tick 3 puts the FSM in CONFIRM; clear lands at the end of cycle 6.
    wait_cycle(5);
    do_reset();
    checks++; if (column !== 3'b110) begin errors++; $display("[TB] FAIL clr_column: got %b expected %b", column, 3'b110); end
    checks++; if (ev_if.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_valid: got %b expected 0", ev_if.key_valid); end
    checks++; if (ev_if.key_down !== 1'b0) begin errors++; $display("[TB] FAIL clr_down: got %b expected 0", ev_if.key_down); end
    wait_cycle(15);
    checks++; if (ev_if.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_count_restart: got %b expected 0", ev_if.key_valid); end
    wait_cycle(16);
    checks++; if (ev_if.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL clr_repress_valid: got %b expected 1", ev_if.key_valid); end
    checks++; if (ev_if.key !== 4'b0001) begin errors++; $display("[TB] FAIL clr_repress_key: got %b expected %b", ev_if.key, 4'b0001); end
    wait_cycle(18);
    enable = 1'b0;
    wait_cycle(19);
    checks++; if (column !== 3'b111) begin errors++; $display("[TB] FAIL dis_column: got %b expected %b", column, 3'b111); end
    checks++; if (ev_if.key_down !== 1'b0) begin errors++; $display("[TB] FAIL dis_down: got %b expected 0", ev_if.key_down); end
    checks++; if (ev_if.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL dis_valid_kept: got %b expected 1", ev_if.key_valid); end
    checks++; if (ev_if.key !== 4'b0001) begin errors++; $display("[TB] FAIL dis_key_kept: got %b expected %b", ev_if.key, 4'b0001); end
    wait_cycle(20);
    enable = 1'b1;
    // Tick counter restarts from 0: hit at 23, post at the end of 35, dropped as overrun.
    wait_cycle(21);
    checks++; if (column !== 3'b110) begin errors++; $display("[TB] FAIL en_column: got %b expected %b", column, 3'b110); end
    wait_cycle(35);
    checks++; if (ev_if.key_down !== 1'b0) begin errors++; $display("[TB] FAIL en_down_early: got %b expected 0", ev_if.key_down); end
    wait_cycle(36);
    checks++; if (ev_if.key_down !== 1'b1) begin errors++; $display("[TB] FAIL en_down: got %b expected 1", ev_if.key_down); end
    checks++; if (ev_if.overrun !== 1'b1) begin errors++; $display("[TB] FAIL en_overrun: got %b expected 1", ev_if.overrun); end
    key_pressed = 1'b0;
  endtask

  initial begin
    clear         = 1'b1;
    enable        = 1'b1;
    ev_if.key_ack = 1'b0;
    key_pressed   = 1'b0;
    press_col     = 2'd0;
    press_row     = 2'd0;
    force_en      = 1'b0;
    force_row     = 3'b111;

    test_reset();
    test_scan_sequence();
    test_press_ack_release();
    test_bounce();
    test_multi_low();
    test_overrun();
    test_back_to_back();
    test_clear_and_enable();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
